// File: rtl/reaction_timer_fsm.sv
// Millisecond reaction-time core: waits a pseudo-random delay, lights GO, then
// counts 1 ms ticks in BCD until the player reacts; early presses are fouls.
module reaction_timer_fsm #(
  parameter int unsigned DELAY_MIN_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] MAX_BCD      = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1k,
  input  logic        start,
  input  logic        react,
  output logic        led_go,
  output logic        done,
  output logic        foul,
  output logic [15:0] ms_bcd
);

  localparam logic [11:0] DelayMin  = 12'(DELAY_MIN_MS);
  localparam logic [15:0] LfsrMask  = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StGo,
    StDone,
    StFoul
  } state_e;

  state_e      state;
  logic [15:0] lfsr;
  logic [11:0] delay_cnt;
  logic        clk1k_d;
  logic        start_d;
  logic        react_d;

  logic        tick;
  logic        start_rise;
  logic        react_rise;
  logic [15:0] lfsr_next;
  logic [11:0] delay_load;
  logic [15:0] ms_inc;

  // Ripple BCD increment: each nibble wraps 9 -> 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    tick       = clk1k & ~clk1k_d;
    start_rise = start & ~start_d;
    react_rise = react & ~react_d;
    lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LfsrMask : 16'h0000);
    delay_load = DelayMin + {1'b0, lfsr[10:0]};
    ms_inc     = bcd_inc(ms_bcd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      lfsr      <= LFSR_SEED;
      delay_cnt <= 12'd0;
      ms_bcd    <= 16'h0000;
      led_go    <= 1'b0;
      done      <= 1'b0;
      foul      <= 1'b0;
      clk1k_d   <= 1'b0;
      start_d   <= 1'b0;
      react_d   <= 1'b0;
    end else begin
      clk1k_d <= clk1k;
      start_d <= start;
      react_d <= react;
      lfsr    <= lfsr_next;
      case (state)
        StIdle: begin
          if (start_rise) begin
            state     <= StWait;
            delay_cnt <= delay_load;
          end
        end
        StWait: begin
          // An early press wins over any same-cycle tick, including the last one.
          if (react_rise) begin
            state <= StFoul;
            foul  <= 1'b1;
          end else if (tick) begin
            if (delay_cnt == 12'd1) begin
              state  <= StGo;
              led_go <= 1'b1;
              ms_bcd <= 16'h0000;
            end else begin
              delay_cnt <= delay_cnt - 12'd1;
            end
          end
        end
        StGo: begin
          if (react_rise) begin
            state  <= StDone;
            led_go <= 1'b0;
            done   <= 1'b1;
          end else if (tick) begin
            if (ms_bcd == MAX_BCD) begin
              state  <= StDone;
              led_go <= 1'b0;
              done   <= 1'b1;
            end else begin
              ms_bcd <= ms_inc;
            end
          end
        end
        StDone, StFoul: begin
          if (start_rise) begin
            state     <= StWait;
            delay_cnt <= delay_load;
            done      <= 1'b0;
            foul      <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          led_go <= 1'b0;
          done   <= 1'b0;
          foul   <= 1'b0;
        end
      endcase
    end
  end

endmodule
